prbs_pattern_gen: RTL and testbench

- Upstream byte source for the PRBS-15 pattern detector.
- Emits a 32-bit user pattern as bytes, repeated n times, then switches to a continuous PRBS-15 byte stream.
- The detector consumes byte_out/byte_valid and checks the pattern run.
- Provides phase and done status so the test harness can align checking windows.

---
 rtl/prbs_pattern_gen.sv | 186 ++++++++++++++++++
 tb/tb_prbs_pattern_gen.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_pattern_gen.sv
// prbs_pattern_gen
//   Byte source for the PRBS-15 pattern detector. On start it emits a
//   32-bit user pattern as bytes, LSB byte first, repeated n times, and then
//   switches to a continuous PRBS-15 byte stream (x^15 + x^14 + 1), eight
//   LFSR steps per byte. The first generated bit lands in byte_out[0].
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   enable       : advance; one byte per clock while high
//   clear        : synchronous return to IDLE, wins over enable
//   pattern[31:0]: pattern word, latched at start
//   n[7:0]       : pattern repetition count, latched at start (0 = straight to PRBS)
//   byte_out     : current output byte (registered)
//   byte_valid   : byte_out was updated this cycle
//   prbs_phase   : byte_out is a PRBS byte
//   pattern_done : one-cycle pulse alongside the last pattern byte
//
// Optional build macro PRBS_GEN_ERR_INJ_EN
//   inj_err      : invert byte_out[0] of the byte emitted on this edge
//                  (PATTERN/PRBS only); counters and LFSR are unaffected
//   err_injected : one-cycle pulse alongside the corrupted byte
module prbs_pattern_gen #(
  parameter logic [14:0] SEED = 15'h7FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] pattern,
  input  logic [7:0]  n,
`ifdef PRBS_GEN_ERR_INJ_EN
  input  logic        inj_err,
  output logic        err_injected,
`endif
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        prbs_phase,
  output logic        pattern_done
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h0001 : SEED;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PATTERN = 2'd1,
    PRBS    = 2'd2
  } state_t;

  state_t      state_q;
  logic [14:0] lfsr_q;
  logic [1:0]  byte_cnt_q;
  logic [7:0]  rep_cnt_q;
  logic [31:0] pat_q;
  logic [7:0]  n_q;
  logic [7:0]  byte_out_q;
  logic        byte_valid_q;
  logic        prbs_phase_q;
  logic        pattern_done_q;

  logic [14:0] lfsr_d;
  logic [7:0]  prbs_byte_d;
  logic [7:0]  pat_byte_d;
  logic [7:0]  inj_mask_d;
  logic        last_pat_byte_d;

  // Eight serial LFSR steps unrolled; returns {next_lfsr, byte}.
  function automatic logic [22:0] prbs_advance8(input logic [14:0] lfsr_in);
    logic [14:0] l;
    logic [7:0]  b;
    logic        nb;
    l = lfsr_in;
    b = 8'h00;
    for (int k = 0; k < 8; k++) begin
      nb   = l[14] ^ l[13];
      l    = {l[13:0], nb};
      b[k] = nb;
    end
    return {l, b};
  endfunction

  always_comb begin
    {lfsr_d, prbs_byte_d} = prbs_advance8(lfsr_q);
    pat_byte_d            = pat_q[{byte_cnt_q, 3'b000} +: 8];
    // Terminal byte: byte 3 of repetition n_q-1 (n_q is never 0 in PATTERN).
    last_pat_byte_d       = (byte_cnt_q == 2'd3) && (rep_cnt_q == (n_q - 8'd1));
`ifdef PRBS_GEN_ERR_INJ_EN
    inj_mask_d            = {7'd0, inj_err};
`else
    inj_mask_d            = 8'h00;
`endif
  end

`ifdef PRBS_GEN_ERR_INJ_EN
  logic err_injected_q;
  assign err_injected = err_injected_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED_EFF;
      byte_cnt_q     <= 2'd0;
      rep_cnt_q      <= 8'd0;
      pat_q          <= 32'd0;
      n_q            <= 8'd0;
      byte_out_q     <= 8'h00;
      byte_valid_q   <= 1'b0;
      prbs_phase_q   <= 1'b0;
      pattern_done_q <= 1'b0;
`ifdef PRBS_GEN_ERR_INJ_EN
      err_injected_q <= 1'b0;
`endif
    end else begin
      // Strobes default low; only an emitting edge raises them.
      byte_valid_q   <= 1'b0;
      pattern_done_q <= 1'b0;
`ifdef PRBS_GEN_ERR_INJ_EN
      err_injected_q <= 1'b0;
`endif
      if (clear) begin
        state_q      <= IDLE;
        lfsr_q       <= SEED_EFF;
        byte_cnt_q   <= 2'd0;
        rep_cnt_q    <= 8'd0;
        prbs_phase_q <= 1'b0;
      end else if (enable) begin
        unique case (state_q)
          IDLE: begin
            pat_q        <= pattern;
            n_q          <= n;
            rep_cnt_q    <= 8'd0;
            byte_valid_q <= 1'b1;
            if (n != 8'd0) begin
              byte_out_q   <= pattern[7:0];
              byte_cnt_q   <= 2'd1;
              prbs_phase_q <= 1'b0;
              state_q      <= PATTERN;
            end else begin
              byte_out_q   <= prbs_byte_d;
              lfsr_q       <= lfsr_d;
              byte_cnt_q   <= 2'd0;
              prbs_phase_q <= 1'b1;
              state_q      <= PRBS;
            end
          end
          PATTERN: begin
            byte_out_q   <= pat_byte_d ^ inj_mask_d;
            byte_valid_q <= 1'b1;
            prbs_phase_q <= 1'b0;
            byte_cnt_q   <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              rep_cnt_q <= rep_cnt_q + 8'd1;
            end
            if (last_pat_byte_d) begin
              pattern_done_q <= 1'b1;
              state_q        <= PRBS;
            end
`ifdef PRBS_GEN_ERR_INJ_EN
            err_injected_q <= inj_err;
`endif
          end
          PRBS: begin
            byte_out_q   <= prbs_byte_d ^ inj_mask_d;
            lfsr_q       <= lfsr_d;
            byte_valid_q <= 1'b1;
            prbs_phase_q <= 1'b1;
`ifdef PRBS_GEN_ERR_INJ_EN
            err_injected_q <= inj_err;
`endif
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign byte_out     = byte_out_q;
  assign byte_valid   = byte_valid_q;
  assign prbs_phase   = prbs_phase_q;
  assign pattern_done = pattern_done_q;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen (default SEED = 15'h7FFF).
// Optional error-injection checks are built when PRBS_GEN_ERR_INJ_EN is defined.
module tb_prbs_pattern_gen;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        clear;
  logic [31:0] pattern;
  logic [7:0]  n;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        prbs_phase;
  logic        pattern_done;
`ifdef PRBS_GEN_ERR_INJ_EN
  logic        inj_err;
  logic        err_injected;
`endif

  int compared;
  int mismatched;

  logic [7:0] ref_q[$];

  prbs_pattern_gen dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clear        (clear),
    .pattern      (pattern),
    .n            (n),
`ifdef PRBS_GEN_ERR_INJ_EN
    .inj_err      (inj_err),
    .err_injected (err_injected),
`endif
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .prbs_phase   (prbs_phase),
    .pattern_done (pattern_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected byte stream: nrep copies of the pattern bytes (LSB first), then
  // nprbs PRBS bytes. The PRBS part is the bit sequence s[t] = s[t-15] ^ s[t-14]
  // seeded by the 15 seed bits (oldest = seed bit 14), packed 8 bits per byte.
  function automatic void build_ref(input logic [31:0] pat, input int nrep, input int nprbs);
    bit          s[$];
    logic [14:0] seed;
    logic [7:0]  v;
    bit          nb;
    ref_q.delete();
    for (int r = 0; r < nrep; r++)
      for (int b = 0; b < 4; b++)
        ref_q.push_back(8'(pat >> (8 * b)));
    seed = 15'h7FFF;
    for (int i = 14; i >= 0; i--) s.push_back(seed[i]);
    for (int k = 0; k < nprbs; k++) begin
      v = 8'h00;
      for (int j = 0; j < 8; j++) begin
        nb = s[s.size() - 15] ^ s[s.size() - 14];
        s.push_back(nb);
        v[j] = nb;
      end
      ref_q.push_back(v);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    clear  = 1'b1;
    enable = 1'($urandom());
    step();
    clear  = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] pat;
    logic [7:0]  nn;
    rst     = 1'b1;
    clear   = 1'($urandom());
    enable  = 1'($urandom());
    pattern = $urandom();
    n       = 8'($urandom());
    repeat (3) step();
    compared++;
    if (byte_out !== 8'h00 || byte_valid !== 1'b0 || prbs_phase !== 1'b0 || pattern_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got out=%h v=%b ph=%b d=%b, want 00/0/0/0", byte_out, byte_valid, prbs_phase, pattern_done);
    end
    pat = $urandom();
    nn  = 8'($urandom_range(1, 255));
    clear = 1'b0; enable = 1'b0; pattern = pat; n = nn;
    #2 rst = 1'b0;
    step();
    compared++;
    if (byte_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle_valid: got %b want 0", byte_valid);
    end
    enable = 1'b1;
    step();
    enable = 1'b0;
    compared++;
    if (byte_out !== pat[7:0] || byte_valid !== 1'b1 || prbs_phase !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_first_byte: got out=%h v=%b ph=%b want %h/1/0", byte_out, byte_valid, prbs_phase, pat[7:0]);
    end
  endtask

  task automatic test_pattern_then_prbs();
    logic [7:0] exp_b [10] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h40};
    go_idle();
    pattern = 32'hDEADBEEF;
    n       = 8'd2;
    enable  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      compared++;
      if (byte_out !== exp_b[i] || byte_valid !== 1'b1 || prbs_phase !== (i >= 8) || pattern_done !== (i == 7)) begin
        mismatched++;
        $display("FAIL pat_prbs[%0d]: got out=%h v=%b ph=%b d=%b want %h/1/%b/%b",
                 i, byte_out, byte_valid, prbs_phase, pattern_done, exp_b[i], (i >= 8), (i == 7));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_n_zero();
    logic [7:0] exp_b [2] = '{8'h00, 8'h40};
    go_idle();
    pattern = 32'h12345678;
    n       = 8'd0;
    enable  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (byte_out !== exp_b[i] || byte_valid !== 1'b1 || prbs_phase !== 1'b1 || pattern_done !== 1'b0) begin
        mismatched++;
        $display("FAIL n_zero[%0d]: got out=%h v=%b ph=%b d=%b want %h/1/1/0",
                 i, byte_out, byte_valid, prbs_phase, pattern_done, exp_b[i]);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_enable_stall();
    logic [7:0] exp_b [4] = '{8'hAD, 8'hDE, 8'h00, 8'h40};
    go_idle();
    pattern = 32'hDEADBEEF;
    n       = 8'd1;
    enable  = 1'b1;
    step();
    step();
    compared++;
    if (byte_out !== 8'hBE || byte_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL stall_pre: got out=%h v=%b want BE/1", byte_out, byte_valid);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      compared++;
      if (byte_out !== 8'hBE || byte_valid !== 1'b0 || pattern_done !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got out=%h v=%b d=%b want BE/0/0", i, byte_out, byte_valid, pattern_done);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      compared++;
      if (byte_out !== exp_b[i] || byte_valid !== 1'b1 || pattern_done !== (i == 1)) begin
        mismatched++;
        $display("FAIL stall_resume[%0d]: got out=%h v=%b d=%b want %h/1/%b", i, byte_out, byte_valid, pattern_done, exp_b[i], (i == 1));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_clear_midrun();
    logic [31:0] p1;
    logic [31:0] p2;
    logic [7:0]  exp_b;
    p1 = $urandom();
    p2 = $urandom();
    go_idle();
    pattern = p1;
    n       = 8'd2;
    enable  = 1'b1;
    step();
    pattern = p2;
    n       = 8'd1;
    for (int i = 1; i < 6; i++) begin
      step();
      exp_b = 8'(p1 >> (8 * (i % 4)));
      compared++;
      if (byte_out !== exp_b || byte_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL midrun_ignore[%0d]: got %h want %h", i, byte_out, exp_b);
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    compared++;
    if (byte_valid !== 1'b0 || pattern_done !== 1'b0) begin
      mismatched++;
      $display("FAIL clear_valid: got v=%b d=%b want 0/0", byte_valid, pattern_done);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      exp_b = (i < 4) ? 8'(p2 >> (8 * i)) : 8'h00;
      compared++;
      if (byte_out !== exp_b || byte_valid !== 1'b1 || prbs_phase !== (i == 4) || pattern_done !== (i == 3)) begin
        mismatched++;
        $display("FAIL clear_restart[%0d]: got out=%h ph=%b d=%b want %h/%b/%b",
                 i, byte_out, prbs_phase, pattern_done, exp_b, (i == 4), (i == 3));
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_random_run(input int nrep, input int nprbs);
    logic [31:0] pat;
    logic [7:0]  last;
    logic        en;
    int          idx;
    int          cyc;
    int          total;
    int          budget;
    pat    = $urandom();
    total  = 4 * nrep + nprbs;
    budget = 8 * total + 20;
    build_ref(pat, nrep, nprbs);
    go_idle();
    pattern = pat;
    n       = 8'(nrep);
    idx     = 0;
    cyc     = 0;
    last    = 8'h00;
    while (idx < total && cyc < budget) begin
      en     = (idx == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      enable = en;
      step();
      cyc++;
      pattern = $urandom();
      n       = 8'($urandom());
      compared++;
      if (en) begin
        if (byte_out !== ref_q[idx] || byte_valid !== 1'b1 || prbs_phase !== (idx >= 4 * nrep) ||
            pattern_done !== (nrep != 0 && idx == 4 * nrep - 1)) begin
          mismatched++;
          $display("FAIL rand_n%0d[%0d]: got out=%h v=%b ph=%b d=%b want %h/1/%b/%b", nrep, idx,
                   byte_out, byte_valid, prbs_phase, pattern_done, ref_q[idx],
                   (idx >= 4 * nrep), (nrep != 0 && idx == 4 * nrep - 1));
        end
        last = ref_q[idx];
        idx++;
      end else begin
        if (byte_out !== last || byte_valid !== 1'b0 || pattern_done !== 1'b0) begin
          mismatched++;
          $display("FAIL rand_hold_n%0d[%0d]: got out=%h v=%b d=%b want %h/0/0", nrep, idx,
                   byte_out, byte_valid, pattern_done, last);
        end
      end
    end
    enable = 1'b0;
    if (idx < total) begin
      compared++;
      mismatched++;
      $display("FAIL rand_timeout_n%0d: got %0d bytes want %0d", nrep, idx, total);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] pat;
    pat = $urandom();
    go_idle();
    pattern = pat;
    n       = 8'd0;
    enable  = 1'b1;
    repeat (3) step();
    #2 rst = 1'b1;
    #1;
    compared++;
    if (byte_out !== 8'h00 || byte_valid !== 1'b0 || prbs_phase !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset: got out=%h v=%b ph=%b want 00/0/0", byte_out, byte_valid, prbs_phase);
    end
    enable = 1'b0;
    step();
    #2 rst = 1'b0;
    pattern = pat;
    n       = 8'd3;
    step();
    compared++;
    if (byte_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_novalid: got %b want 0", byte_valid);
    end
    enable = 1'b1;
    step();
    enable = 1'b0;
    compared++;
    if (byte_out !== pat[7:0] || byte_valid !== 1'b1 || prbs_phase !== 1'b0) begin
      mismatched++;
      $display("FAIL async_reset_restart: got out=%h v=%b ph=%b want %h/1/0", byte_out, byte_valid, prbs_phase, pat[7:0]);
    end
  endtask

`ifdef PRBS_GEN_ERR_INJ_EN
  task automatic test_err_inj();
    build_ref(32'h0, 0, 8);
    go_idle();
    pattern = $urandom();
    n       = 8'd0;
    enable  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inj_err = (i == 1);
      step();
      compared++;
      if (byte_out !== (ref_q[i] ^ ((i == 1) ? 8'h01 : 8'h00)) || err_injected !== (i == 1) || byte_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL err_inj[%0d]: got out=%h e=%b want %h/%b", i, byte_out, err_injected,
                 ref_q[i] ^ ((i == 1) ? 8'h01 : 8'h00), (i == 1));
      end
    end
    inj_err = 1'b0;
    enable  = 1'b0;
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    clear      = 1'b0;
    pattern    = 32'd0;
    n          = 8'd0;
`ifdef PRBS_GEN_ERR_INJ_EN
    inj_err    = 1'b0;
`endif
    test_reset();
    test_pattern_then_prbs();
    test_n_zero();
    test_enable_stall();
    test_clear_midrun();
    test_random_run(0, 40);
    test_random_run(1, 20);
    test_random_run($urandom_range(2, 6), 30);
    test_random_run(255, 6);
    test_async_reset();
`ifdef PRBS_GEN_ERR_INJ_EN
    test_err_inj();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
